// File: rtl/stdp_pkg.sv
// Shared types for the STDP pair scheduler.
// State encoding, update record and round-robin index helper.
package stdp_pkg;

    localparam int HIST_W = 16;
    localparam int TD_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } sched_state_t;

    typedef struct packed {
        logic [4:0]      pair;
        logic [TD_W-1:0] td;
        logic            sign;
    } stdp_upd_t;

    function automatic int wrap_idx(int base, int off, int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/stdp_rr_arbiter.sv
// Round-robin arbiter: first set pending bit at or after ptr wins.
// Purely combinational; the caller owns ptr and pend.
module stdp_rr_arbiter
    import stdp_pkg::*;
#(
    parameter int N_PAIRS = 8,
    localparam int IDX_W  = $clog2(N_PAIRS)
) (
    input  logic [N_PAIRS-1:0] pend,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_PAIRS-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [IDX_W-1:0] sel;

    // Walk from farthest to nearest so the nearest set bit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        sel     = '0;
        for (int k = N_PAIRS - 1; k >= 0; k--) begin
            sel = IDX_W'(wrap_idx(int'(ptr), k, N_PAIRS));
            if (pend[sel]) begin
                gnt      = '0;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

    assign gnt_any = |pend;

endmodule

// File: rtl/stdp_pair_scheduler.sv
// Shares one timing-difference encoder across N_PAIRS synapse pairs.
// Latches spike requests, arbitrates round-robin, returns (td, sign) records.
module stdp_pair_scheduler
    import stdp_pkg::*;
#(
    parameter int N_PAIRS = 8,
    parameter int HIST_W  = 16,
    parameter int OVF_W   = 8,
    localparam int IDX_W  = $clog2(N_PAIRS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PAIRS-1:0]        spike_req,
    input  logic [N_PAIRS*HIST_W-1:0] pre_hist,
    input  logic [N_PAIRS*HIST_W-1:0] post_hist,
    output logic [HIST_W-1:0]         enc_pre,
    output logic [HIST_W-1:0]         enc_post,
    input  logic [TD_W-1:0]           enc_td,
    input  logic                      enc_sign,
    output logic                      upd_valid,
    input  logic                      upd_ready,
    output logic [IDX_W-1:0]          upd_pair,
    output logic [TD_W-1:0]           upd_td,
    output logic                      upd_sign,
    output logic                      busy,
    output logic [OVF_W-1:0]          ovf_cnt
);

    localparam int SUM_W = OVF_W + 6;

    sched_state_t       state, state_nxt;
    logic [N_PAIRS-1:0] pend, gnt, gclr, ovf_hits;
    logic [IDX_W-1:0]   ptr, gnt_idx, cur;
    logic               gnt_any, do_grant, live;
    logic [HIST_W-1:0]  cur_pre, cur_post;
    logic [SUM_W-1:0]   ovf_sum;
    stdp_upd_t          rec;

    stdp_rr_arbiter #(.N_PAIRS(N_PAIRS)) u_arb (
        .pend    (pend),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign cur      = rec.pair[IDX_W-1:0];
    assign cur_pre  = pre_hist[cur*HIST_W +: HIST_W];
    assign cur_post = post_hist[cur*HIST_W +: HIST_W];
    assign live     = cur_pre[HIST_W-1] | cur_post[HIST_W-1];

    assign do_grant = gnt_any &
                      ((state == IDLE) | ((state == OUT) & upd_ready));
    assign gclr     = do_grant ? gnt : '0;
    // A request on a bit that stays pending is merged, not queued.
    assign ovf_hits = spike_req & pend & ~gclr;
    assign ovf_sum  = SUM_W'(ovf_cnt) + SUM_W'($countones(ovf_hits));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (gnt_any) state_nxt = ISSUE;
            ISSUE: state_nxt = live ? WAIT : IDLE;
            WAIT:  state_nxt = OUT;
            OUT:   if (upd_ready) state_nxt = gnt_any ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= '0;
            ptr     <= '0;
            rec     <= '0;
            ovf_cnt <= '0;
        end else begin
            pend <= (pend & ~gclr) | spike_req;
            if (do_grant) begin
                rec.pair <= 5'(gnt_idx);
                ptr      <= (gnt_idx == IDX_W'(N_PAIRS - 1)) ?
                            '0 : gnt_idx + 1'b1;
            end
            if (state == WAIT) begin
                rec.td   <= enc_td;
                rec.sign <= enc_sign;
            end
            if (ovf_sum > SUM_W'({OVF_W{1'b1}})) ovf_cnt <= '1;
            else ovf_cnt <= ovf_sum[OVF_W-1:0];
        end
    end

    always_comb begin
        enc_pre   = '0;
        enc_post  = '0;
        upd_valid = 1'b0;
        if (state == ISSUE) begin
            enc_pre  = cur_pre;
            enc_post = cur_post;
        end
        if (state == OUT) upd_valid = 1'b1;
    end

    assign busy     = (state != IDLE) | (|pend);
    assign upd_pair = cur;
    assign upd_td   = rec.td;
    assign upd_sign = rec.sign;

endmodule

// File: tb/tb_stdp_pair_scheduler.sv
// Bench for stdp_pair_scheduler: directed scenarios plus random traffic
// against a transaction-age reference model and an encoder stand-in.
module tb_stdp_pair_scheduler;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   spike_req;
    logic [N*16-1:0] pre_hist, post_hist;
    logic [15:0]    enc_pre, enc_post;
    logic [3:0]     enc_td;
    logic           enc_sign;
    logic           upd_valid, upd_ready;
    logic [2:0]     upd_pair;
    logic [3:0]     upd_td;
    logic           upd_sign, busy;
    logic [7:0]     ovf_cnt;

    stdp_pair_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .spike_req (spike_req),
        .pre_hist  (pre_hist),
        .post_hist (post_hist),
        .enc_pre   (enc_pre),
        .enc_post  (enc_post),
        .enc_td    (enc_td),
        .enc_sign  (enc_sign),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_pair  (upd_pair),
        .upd_td    (upd_td),
        .upd_sign  (upd_sign),
        .busy      (busy),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    function automatic int msb_of(logic [15:0] x);
        for (int b = 15; b >= 0; b--) if (x[b]) return b;
        return -1;
    endfunction

    // Encoder behaviour: post has priority; td = age of the other side's latest spike.
    function automatic logic [4:0] enc_fn(logic [15:0] pre, logic [15:0] post);
        int m;
        if (post[15]) begin
            m = msb_of(pre);
            return {1'b0, 4'(m < 0 ? 0 : 15 - m)};
        end
        if (pre[15]) begin
            m = msb_of(post);
            return {1'b1, 4'(m < 0 ? 0 : 15 - m)};
        end
        return 5'd0;
    endfunction

    logic [15:0] e_pre = '0, e_post = '0;
    always @(posedge clk)
        if ((enc_pre | enc_post) != 16'd0) begin
            e_pre  <= enc_pre;
            e_post <= enc_post;
        end
    assign {enc_sign, enc_td} = enc_fn(e_pre, e_post);

    typedef struct {
        int cyc;
        int pair;
        int td;
        int sign;
    } rec_t;
    rec_t obs[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: pending set, pointer, and the current job with its age.
    bit m_pend[N];
    int m_ptr, m_pair, m_td, m_sign, m_ovf, m_age;
    bit m_job;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_ptr = 0; m_job = 0; m_age = 0; m_pair = 0;
        m_td = 0; m_sign = 0; m_ovf = 0;
    endtask

    function automatic int first_pend();
        for (int k = 0; k < N; k++)
            if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic bit any_pend();
        foreach (m_pend[i]) if (m_pend[i]) return 1;
        return 0;
    endfunction

    task automatic model_step();
        int g;
        bit gr;
        logic [15:0] p, q;
        logic [4:0] e;
        if (rst) begin
            model_reset();
            return;
        end
        g  = first_pend();
        gr = 0;
        if (!m_job) begin
            if (g >= 0) begin gr = 1; m_job = 1; m_age = 1; m_pair = g; end
        end else if (m_age == 1) begin
            p = pre_hist[m_pair*16 +: 16];
            q = post_hist[m_pair*16 +: 16];
            if (p[15] | q[15]) begin
                e = enc_fn(p, q);
                m_td = int'(e[3:0]); m_sign = int'(e[4]); m_age = 2;
            end else m_job = 0;
        end else if (m_age == 2) begin
            m_age = 3;
        end else if (upd_ready) begin
            if (g >= 0) begin gr = 1; m_age = 1; m_pair = g; end
            else m_job = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (gr && i == g) m_pend[i] = spike_req[i];
            else if (spike_req[i]) begin
                if (m_pend[i]) m_ovf = (m_ovf >= 255) ? 255 : m_ovf + 1;
                else m_pend[i] = 1;
            end
        end
        if (gr) m_ptr = (g + 1) % N;
    endtask

    task automatic check_outputs();
        logic [15:0] xp, xq;
        bit issuing;
        issuing = m_job && m_age == 1;
        xp = issuing ? pre_hist[m_pair*16 +: 16] : 16'd0;
        xq = issuing ? post_hist[m_pair*16 +: 16] : 16'd0;
        chk("enc_pre", 32'(enc_pre), 32'(xp));
        chk("enc_post", 32'(enc_post), 32'(xq));
        chk("upd_valid", 32'(upd_valid), 32'(m_job && m_age == 3));
        chk("busy", 32'(busy), 32'(m_job || any_pend()));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
        if (m_job && m_age == 3) begin
            chk("upd_pair", 32'(upd_pair), 32'(m_pair));
            chk("upd_td", 32'(upd_td), 32'(m_td));
            chk("upd_sign", 32'(upd_sign), 32'(m_sign));
        end
        if (upd_valid === 1'b1 && upd_ready && !rst)
            obs.push_back('{cyc, int'(upd_pair), int'(upd_td), int'(upd_sign)});
    endtask

    task automatic step(input logic [N-1:0] req, input logic rdy, input logic r);
        spike_req = req;
        upd_ready = rdy;
        rst       = r;
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_obs(input int n, input int limit);
        int k;
        k = 0;
        while (obs.size() < n && k < limit) begin
            step('0, 1'b1, 1'b0);
            k++;
        end
        if (obs.size() < n) chk("obs_timeout", 32'(obs.size()), 32'(n));
    endtask

    task automatic set_hist(input int p, input logic [15:0] pre,
                            input logic [15:0] post);
        pre_hist[p*16 +: 16]  = pre;
        post_hist[p*16 +: 16] = post;
    endtask

    initial begin
        int t0, k;
        logic [N-1:0] rq;
        spike_req = '0; upd_ready = 1'b1; rst = 1'b1;
        pre_hist = '0; post_hist = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();

        // Idle after reset
        for (int i = 0; i < 10; i++) step('0, 1'b1, 1'b0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ovf", 32'(ovf_cnt), 32'd0);

        // Single event and its mirror
        set_hist(3, 16'h0400, 16'h8000);
        obs.delete();
        t0 = cyc;
        step(8'h08, 1'b1, 1'b0);
        run_until_obs(1, 20);
        if (obs.size() >= 1) begin
            chk("lat", 32'(obs[0].cyc - t0), 32'd4);
            chk("t2_pair", 32'(obs[0].pair), 32'd3);
            chk("t2_td", 32'(obs[0].td), 32'd5);
            chk("t2_sign", 32'(obs[0].sign), 32'd0);
        end
        set_hist(6, 16'h8000, 16'h0002);
        obs.delete();
        step(8'h40, 1'b1, 1'b0);
        run_until_obs(1, 20);
        if (obs.size() >= 1) begin
            chk("mir_td", 32'(obs[0].td), 32'd14);
            chk("mir_sign", 32'(obs[0].sign), 32'd1);
        end

        // Round-robin order from ptr 0, then from ptr 7
        step('0, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) set_hist(i, 16'h0400, 16'h8000);
        obs.delete();
        step(8'b0110_0010, 1'b1, 1'b0);
        run_until_obs(3, 30);
        if (obs.size() >= 3) begin
            chk("rr0", 32'(obs[0].pair), 32'd1);
            chk("rr1", 32'(obs[1].pair), 32'd5);
            chk("rr2", 32'(obs[2].pair), 32'd6);
        end
        obs.delete();
        step(8'b0100_0001, 1'b1, 1'b0);
        run_until_obs(2, 30);
        if (obs.size() >= 2) begin
            chk("rr_wrap0", 32'(obs[0].pair), 32'd0);
            chk("rr_wrap1", 32'(obs[1].pair), 32'd6);
        end

        // Backpressure: hold in OUT, then release into the next pair
        set_hist(4, 16'h0100, 16'h8000);
        step(8'h14, 1'b0, 1'b0);
        k = 0;
        while (upd_valid !== 1'b1 && k < 10) begin
            step('0, 1'b0, 1'b0);
            k++;
        end
        for (int i = 0; i < 5; i++) step('0, 1'b0, 1'b0);
        chk("bp_valid", 32'(upd_valid), 32'd1);
        chk("bp_pair", 32'(upd_pair), 32'd2);
        chk("bp_td", 32'(upd_td), 32'd5);
        obs.delete();
        step('0, 1'b1, 1'b0);
        chk("bp_next_pre", 32'(enc_pre), 32'h0100);
        chk("bp_next_post", 32'(enc_post), 32'h8000);
        run_until_obs(2, 20);

        // Overflow, dead pair dropped, both MSBs set
        step('0, 1'b1, 1'b1);
        step(8'h02, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        chk("ovf_one", 32'(ovf_cnt), 32'd1);
        obs.delete();
        run_until_obs(2, 30);
        set_hist(4, 16'h0000, 16'h0000);
        obs.delete();
        step(8'h10, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step('0, 1'b1, 1'b0);
        chk("drop_none", 32'(obs.size()), 32'd0);
        chk("drop_idle", 32'(busy), 32'd0);
        set_hist(5, 16'h8000, 16'h8000);
        obs.delete();
        step(8'h20, 1'b1, 1'b0);
        run_until_obs(1, 20);
        if (obs.size() >= 1) begin
            chk("both_pair", 32'(obs[0].pair), 32'd5);
            chk("both_td", 32'(obs[0].td), 32'd0);
            chk("both_sign", 32'(obs[0].sign), 32'd0);
        end

        // Reset while in WAIT with three pairs pending
        for (int i = 0; i < 4; i++) set_hist(i, 16'h0400, 16'h8000);
        obs.delete();
        step(8'h01, 1'b1, 1'b0);
        step(8'h0E, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b1);
        chk("rst_valid", 32'(upd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_enc", 32'(enc_pre | enc_post), 32'd0);
        for (int i = 0; i < 12; i++) step('0, 1'b1, 1'b0);
        chk("rst_no_stale", 32'(obs.size()), 32'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            pre_hist  = {$urandom, $urandom, $urandom, $urandom};
            post_hist = {$urandom, $urandom, $urandom, $urandom};
            rq = '0;
            for (int i = 0; i < N; i++) rq[i] = ($urandom_range(0, 5) == 0);
            step(rq, $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
